// File: rtl/lif_neuron_pool.sv
// Time-multiplexed leaky integrate-and-fire neuron population.
// Each neuron gets two clocks per sweep. In READ, its membrane value, its
// refractory count and i_in are captured. In UPDATE, the neuron is leaked,
// integrated, thresholded and written back. Every update result is reported
// during the READ cycle that follows it.
module lif_neuron_pool #(
  parameter int                 N_NEURONS  = 128,
  parameter int                 IDX_W      = 7,
  parameter logic signed [31:0] V_THRESH   = 32'sd30720,
  parameter logic signed [31:0] V_RESET    = 32'sd0,
  parameter int                 REFRACT    = 2,
  parameter int                 LEAK_SHIFT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [31:0]  i_in,
  output logic [IDX_W-1:0]    i_index,
  output logic                phase,
  output logic                out_valid,
  output logic                spike_out,
  output logic [IDX_W-1:0]    spike_index,
  output logic signed [31:0]  v_out,
  output logic                sweep_done,
  output logic [IDX_W:0]      pop_spike_count
);

  typedef enum logic {PH_READ = 1'b0, PH_UPDATE = 1'b1} phase_t;

  phase_t                    r_phase;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_firstPass;
  logic [IDX_W:0]            r_runCount;
  logic signed [31:0]        r_v;
  logic [3:0]                r_ref;
  logic signed [31:0]        r_in;

  logic signed [31:0]        r_vMem   [N_NEURONS];
  logic [3:0]                r_refMem [N_NEURONS];

  logic signed [31:0]        w_leak;
  logic signed [33:0]        w_vExt;
  logic signed [33:0]        w_leakExt;
  logic signed [33:0]        w_inExt;
  logic signed [33:0]        w_sum;
  logic signed [31:0]        w_vInt;
  logic                      w_refActive;
  logic                      w_spike;
  logic signed [31:0]        w_vNew;
  logic [3:0]                w_refNew;
  logic                      w_lastIdx;
  logic [IDX_W:0]            w_spikeExt;

  assign i_index = r_idx;
  assign phase   = r_phase;

  // Leak, integrate, saturate and threshold the neuron captured in the last READ
  always_comb begin
    w_leak      = r_v >>> LEAK_SHIFT;
    w_vExt      = {{2{r_v[31]}}, r_v};
    w_leakExt   = {{2{w_leak[31]}}, w_leak};
    w_inExt     = {{2{r_in[31]}}, r_in};
    w_sum       = w_vExt - w_leakExt + w_inExt;
    if (w_sum[33:31] == 3'b000 || w_sum[33:31] == 3'b111) begin
      w_vInt = w_sum[31:0];
    end else if (w_sum[33]) begin
      w_vInt = 32'sh8000_0000;
    end else begin
      w_vInt = 32'sh7FFF_FFFF;
    end
    w_refActive = (r_ref != 4'd0);
    w_spike     = !w_refActive && (w_vInt >= V_THRESH);
    w_vNew      = (w_refActive || w_spike) ? V_RESET : w_vInt;
    if (w_refActive) begin
      w_refNew = r_ref - 4'd1;
    end else if (w_spike) begin
      w_refNew = 4'(REFRACT);
    end else begin
      w_refNew = 4'd0;
    end
    w_lastIdx   = (r_idx == IDX_W'(N_NEURONS - 1));
    w_spikeExt  = {{IDX_W{1'b0}}, w_spike};
  end

  // READ/UPDATE schedule, operand capture, result reporting and spike counting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase         <= PH_READ;
      r_idx           <= '0;
      r_firstPass     <= 1'b1;
      r_runCount      <= '0;
      r_v             <= '0;
      r_ref           <= '0;
      r_in            <= '0;
      out_valid       <= 1'b0;
      spike_out       <= 1'b0;
      spike_index     <= '0;
      v_out           <= '0;
      sweep_done      <= 1'b0;
      pop_spike_count <= '0;
    end else begin
      out_valid  <= 1'b0;
      sweep_done <= 1'b0;
      case (r_phase)
        PH_READ: begin
          r_v     <= r_firstPass ? V_RESET : r_vMem[r_idx];
          r_ref   <= r_firstPass ? 4'd0 : r_refMem[r_idx];
          r_in    <= i_in;
          r_phase <= PH_UPDATE;
        end
        PH_UPDATE: begin
          out_valid   <= 1'b1;
          spike_out   <= w_spike;
          spike_index <= r_idx;
          v_out       <= w_vNew;
          r_phase     <= PH_READ;
          r_idx       <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
          if (w_lastIdx) begin
            pop_spike_count <= r_runCount + w_spikeExt;
            sweep_done      <= 1'b1;
            r_runCount      <= '0;
            r_firstPass     <= 1'b0;
          end else begin
            r_runCount <= r_runCount + w_spikeExt;
          end
        end
        default: r_phase <= PH_READ;
      endcase
    end
  end

  // Membrane and refractory write-back; stale contents after reset are masked by first-pass
  always_ff @(posedge clk) begin
    if (!reset && r_phase == PH_UPDATE) begin
      r_vMem[r_idx]   <= w_vNew;
      r_refMem[r_idx] <= w_refNew;
    end
  end

endmodule
